// File: rtl/core_pkg.sv
// Stage codes shared by the sequencer, decoder and datapath.
package core_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WRITE  = ST_WRITE,
        S_HALT   = ST_HALT
    } stage_e;

    // Counter width able to hold a wait limit; never narrower than one bit.
    function automatic int timer_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Down-counting wait timer. clr_i loads LIMIT, en_i counts one wait cycle,
// tc_o flags that the current wait cycle is the LIMIT-th one.
module seq_wait_timer
    import core_pkg::*;
#(
    parameter int unsigned LIMIT = 64,
    parameter int          W     = timer_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] LOAD_W = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load on clear, otherwise decrement while enabled, saturating at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD_W;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control FSM.
//   state  | meaning
//   FETCH  | instr_req high until instr_valid
//   DECODE | single cycle
//   EXEC   | FPU / input-port / output-port handshake, else one cycle
//   MEM    | mem_req high until mem_ready, else one cycle
//   WRITE  | pc_en/wb_en, retire; go to HALT if a halt is pending
//   HALT   | idle until reset
module core_sequencer
    import core_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned FPU_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic [STATE_W-1:0] state,
    output logic               instr_req,
    input  logic               instr_valid,
    input  logic               use_fpu,
    input  logic               data_in,
    input  logic               data_out,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               fpu_start,
    input  logic               fpu_done,
    input  logic               in_valid,
    output logic               in_pop,
    input  logic               out_ready,
    output logic               out_push,
    output logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               wb_en,
    input  logic               halt_req,
    output logic               fpu_err,
    output logic [CNT_W-1:0]   instret
);

    stage_e           state_q, state_d;
    logic             first_q, first_d;
    logic             fpu_q, fpu_d;
    logic             in_q, in_d;
    logic             out_q, out_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic tmr_clr, tmr_en, tmr_tc;
    logic eff_fpu, eff_in, eff_out;
    logic mem_acc;

    seq_wait_timer #(
        .LIMIT (FPU_TIMEOUT)
    ) u_fpu_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // The decoder flags are only valid in the first EXEC cycle; use them
    // live there and the latched copies afterwards.
    assign eff_fpu = first_q ? use_fpu  : fpu_q;
    assign eff_in  = first_q ? data_in  : in_q;
    assign eff_out = first_q ? data_out : out_q;
    assign mem_acc = mem_read | mem_write;

    // Next-state, strobes and flag updates.
    always_comb begin
        state_d   = state_q;
        first_d   = (state_q == S_DECODE);
        fpu_d     = fpu_q;
        in_d      = in_q;
        out_d     = out_q;
        halt_d    = halt_q | halt_req;
        err_d     = err_q;
        instret_d = instret_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        instr_req = 1'b0;
        fpu_start = 1'b0;
        in_pop    = 1'b0;
        out_push  = 1'b0;
        mem_req   = 1'b0;
        pc_en     = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (first_q) begin
                    fpu_d = use_fpu;
                    in_d  = data_in;
                    out_d = data_out;
                end
                if (eff_fpu) begin
                    if (first_q) begin
                        fpu_start = 1'b1;
                        tmr_clr   = 1'b1;
                    end else if (fpu_done) begin
                        state_d = S_MEM;
                    end else if ((FPU_TIMEOUT != 0) && tmr_tc) begin
                        err_d   = 1'b1;
                        state_d = S_MEM;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end else if (eff_in) begin
                    in_pop = in_valid;
                    if (in_valid) state_d = S_MEM;
                end else if (eff_out) begin
                    out_push = out_ready;
                    if (out_ready) state_d = S_MEM;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                mem_req = mem_acc;
                if (!mem_acc || mem_ready) state_d = S_WRITE;
            end
            S_WRITE: begin
                pc_en     = 1'b1;
                wb_en     = 1'b1;
                instret_d = instret_q + 1'b1;
                state_d   = (halt_req || halt_q) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            first_q   <= 1'b0;
            fpu_q     <= 1'b0;
            in_q      <= 1'b0;
            out_q     <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            fpu_q     <= fpu_d;
            in_q      <= in_d;
            out_q     <= out_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign fpu_err = err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: one instance with the default FPU
// timeout and one with FPU_TIMEOUT=4, driven by the same stimulus.
module tb_core_sequencer;

    logic clk = 1'b0;
    logic rst, instr_valid, use_fpu, data_in, data_out, mem_read, mem_write;
    logic fpu_done, in_valid, out_ready, mem_ready, halt_req;
    logic use4;

    logic [2:0]  state1, state4;
    logic        instr_req1, fpu_start1, in_pop1, out_push1, mem_req1, pc_en1, wb_en1, fpu_err1;
    logic        instr_req4, fpu_start4, in_pop4, out_push4, mem_req4, pc_en4, wb_en4, fpu_err4;
    logic [31:0] instret1, instret4;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    core_sequencer #(.CNT_W(32), .FPU_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .state(state1), .instr_req(instr_req1),
        .instr_valid(instr_valid), .use_fpu(use_fpu), .data_in(data_in),
        .data_out(data_out), .mem_read(mem_read), .mem_write(mem_write),
        .fpu_start(fpu_start1), .fpu_done(fpu_done), .in_valid(in_valid),
        .in_pop(in_pop1), .out_ready(out_ready), .out_push(out_push1),
        .mem_req(mem_req1), .mem_ready(mem_ready), .pc_en(pc_en1), .wb_en(wb_en1),
        .halt_req(halt_req), .fpu_err(fpu_err1), .instret(instret1)
    );

    core_sequencer #(.CNT_W(32), .FPU_TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .state(state4), .instr_req(instr_req4),
        .instr_valid(instr_valid), .use_fpu(use_fpu), .data_in(data_in),
        .data_out(data_out), .mem_read(mem_read), .mem_write(mem_write),
        .fpu_start(fpu_start4), .fpu_done(fpu_done), .in_valid(in_valid),
        .in_pop(in_pop4), .out_ready(out_ready), .out_push(out_push4),
        .mem_req(mem_req4), .mem_ready(mem_ready), .pc_en(pc_en4), .wb_en(wb_en4),
        .halt_req(halt_req), .fpu_err(fpu_err4), .instret(instret4)
    );

    // Strobes packed as {instr_req, fpu_start, in_pop, out_push, mem_req, pc_en, wb_en}.
    wire [6:0] sb1 = {instr_req1, fpu_start1, in_pop1, out_push1, mem_req1, pc_en1, wb_en1};
    wire [6:0] sb4 = {instr_req4, fpu_start4, in_pop4, out_push4, mem_req4, pc_en4, wb_en4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check stage and strobes mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input logic [2:0] st, input logic [6:0] sb);
        @(negedge clk);
        chk({tag, ".state"}, 32'(use4 ? state4 : state1), 32'(st));
        chk({tag, ".strobes"}, 32'(use4 ? sb4 : sb1), 32'(sb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b1; use_fpu = 1'b0; data_in = 1'b0; data_out = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; fpu_done = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1; mem_ready = 1'b1; halt_req = 1'b0; use4 = 1'b0;

        // Reset state, then a plain ALU instruction with everything ready.
        do_reset();
        chk("rst.instret", instret1, 32'd0);
        chk("rst.fpu_err", 32'(fpu_err1), 32'd0);
        step("t1.fetch", 3'd0, 7'b1000000);
        step("t1.decode", 3'd1, 7'b0000000);
        step("t1.exec", 3'd2, 7'b0000000);
        step("t1.mem", 3'd3, 7'b0000000);
        step("t1.write", 3'd4, 7'b0000011);
        chk("t1.instret", instret1, 32'd1);

        // Fetch stall, then a load whose mem_ready arrives 3 cycles late.
        instr_valid = 1'b0;
        step("t2.fstall", 3'd0, 7'b1000000);
        instr_valid = 1'b1; mem_read = 1'b1; mem_ready = 1'b0;
        step("t2.fetch", 3'd0, 7'b1000000);
        step("t2.decode", 3'd1, 7'b0000000);
        step("t2.exec", 3'd2, 7'b0000000);
        step("t2.mem0", 3'd3, 7'b0000100);
        step("t2.mem1", 3'd3, 7'b0000100);
        step("t2.mem2", 3'd3, 7'b0000100);
        mem_ready = 1'b1;
        step("t2.mem3", 3'd3, 7'b0000100);
        mem_read = 1'b0;
        step("t2.write", 3'd4, 7'b0000011);
        chk("t2.instret", instret1, 32'd2);

        // FPU op: fpu_done in the launch cycle is ignored, real done 6 cycles later.
        step("t3.fetch", 3'd0, 7'b1000000);
        step("t3.decode", 3'd1, 7'b0000000);
        use_fpu = 1'b1; fpu_done = 1'b1;
        step("t3.exec0", 3'd2, 7'b0100000);
        use_fpu = 1'b0; fpu_done = 1'b0;
        for (int i = 1; i < 6; i++) step("t3.wait", 3'd2, 7'b0000000);
        fpu_done = 1'b1;
        step("t3.exec6", 3'd2, 7'b0000000);
        fpu_done = 1'b0;
        step("t3.mem", 3'd3, 7'b0000000);
        step("t3.write", 3'd4, 7'b0000011);
        chk("t3.instret", instret1, 32'd3);
        chk("t3.fpu_err", 32'(fpu_err1), 32'd0);

        // FPU timeout of 4 waits on the second instance.
        do_reset();
        use4 = 1'b1;
        step("t4.fetch", 3'd0, 7'b1000000);
        step("t4.decode", 3'd1, 7'b0000000);
        use_fpu = 1'b1;
        step("t4.exec0", 3'd2, 7'b0100000);
        use_fpu = 1'b0;
        for (int i = 1; i < 4; i++) step("t4.wait", 3'd2, 7'b0000000);
        chk("t4.err_before", 32'(fpu_err4), 32'd0);
        step("t4.wait4", 3'd2, 7'b0000000);
        chk("t4.err_after", 32'(fpu_err4), 32'd1);
        step("t4.mem", 3'd3, 7'b0000000);
        step("t4.write", 3'd4, 7'b0000011);
        chk("t4.instret", instret4, 32'd1);
        step("t4.fetch2", 3'd0, 7'b1000000);
        chk("t4.err_sticky", 32'(fpu_err4), 32'd1);
        use4 = 1'b0;

        // Input-port op with in_valid low for 10 cycles.
        do_reset();
        step("t5.fetch", 3'd0, 7'b1000000);
        step("t5.decode", 3'd1, 7'b0000000);
        data_in = 1'b1; in_valid = 1'b0;
        step("t5.exec0", 3'd2, 7'b0000000);
        data_in = 1'b0;
        for (int i = 1; i < 10; i++) step("t5.wait", 3'd2, 7'b0000000);
        in_valid = 1'b1;
        step("t5.exec10", 3'd2, 7'b0010000);
        step("t5.mem", 3'd3, 7'b0000000);
        step("t5.write", 3'd4, 7'b0000011);
        // Output-port op with out_ready already high.
        step("t5o.fetch", 3'd0, 7'b1000000);
        step("t5o.decode", 3'd1, 7'b0000000);
        data_out = 1'b1;
        step("t5o.exec0", 3'd2, 7'b0001000);
        data_out = 1'b0;
        step("t5o.mem", 3'd3, 7'b0000000);
        step("t5o.write", 3'd4, 7'b0000011);
        // Both port flags set: input wins.
        step("t5p.fetch", 3'd0, 7'b1000000);
        step("t5p.decode", 3'd1, 7'b0000000);
        data_in = 1'b1; data_out = 1'b1;
        step("t5p.exec0", 3'd2, 7'b0010000);
        data_in = 1'b0; data_out = 1'b0;
        step("t5p.mem", 3'd3, 7'b0000000);
        step("t5p.write", 3'd4, 7'b0000011);
        chk("t5.instret", instret1, 32'd3);

        // Reset during a pending store, then a halt request during EXEC.
        step("t6.fetch", 3'd0, 7'b1000000);
        step("t6.decode", 3'd1, 7'b0000000);
        mem_write = 1'b1; mem_ready = 1'b0;
        step("t6.exec", 3'd2, 7'b0000000);
        step("t6.mem0", 3'd3, 7'b0000100);
        rst = 1'b1;
        step("t6.mem_rst", 3'd3, 7'b0000100);
        rst = 1'b0;
        chk("t6.instret_rst", instret1, 32'd0);
        step("t6.after_rst", 3'd0, 7'b1000000);
        mem_write = 1'b0; mem_ready = 1'b1;
        step("t6.decode2", 3'd1, 7'b0000000);
        halt_req = 1'b1;
        step("t6.exec2", 3'd2, 7'b0000000);
        halt_req = 1'b0;
        step("t6.mem2", 3'd3, 7'b0000000);
        step("t6.write2", 3'd4, 7'b0000011);
        for (int i = 0; i < 3; i++) step("t6.halt", 3'd5, 7'b0000000);
        chk("t6.instret", instret1, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
